// File: rtl/ex_mem_elastic_barrier_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : ex_mem_elastic_barrier_pkg                                    |
// | Brief   : Default widths and EX->MEM payload packing layout shared by   |
// |           the elastic barrier, its interface and its payload registers.  |
// | Rev     : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
package ex_mem_elastic_barrier_pkg;

  localparam int DEFAULT_DATA_WIDTH      = 32;
  localparam int DEFAULT_REG_INDEX_WIDTH = 5;
  localparam int DEFAULT_STALL_CNT_WIDTH = 16;

  // Payload layout, LSB first: regWrite, memToReg, memWrite, index, wdata, alu.
  // Control bits sit at fixed offsets so they never move with the data widths.
  localparam int PL_REG_WRITE_BIT  = 0;
  localparam int PL_MEM_TO_REG_BIT = 1;
  localparam int PL_MEM_WRITE_BIT  = 2;
  localparam int PL_IDX_LSB        = 3;

  function automatic int pl_wdata_lsb(input int reg_index_width);
    return PL_IDX_LSB + reg_index_width;
  endfunction

  function automatic int pl_alu_lsb(input int data_width, input int reg_index_width);
    return PL_IDX_LSB + reg_index_width + data_width;
  endfunction

  function automatic int payload_width(input int data_width, input int reg_index_width);
    return PL_IDX_LSB + reg_index_width + 2 * data_width;
  endfunction

  localparam int PAYLOAD_WIDTH = payload_width(DEFAULT_DATA_WIDTH, DEFAULT_REG_INDEX_WIDTH);

endpackage
`default_nettype wire

// File: rtl/ex_mem_elastic_barrier_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : ex_mem_elastic_barrier_if                                   |
// | Brief     : EX-side and MEM-side handshake/payload bundle of the        |
// |             EX->MEM elastic barrier. slave = barrier view,             |
// |             master = surrounding pipeline view.                        |
// | Rev       : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface ex_mem_elastic_barrier_if
  import ex_mem_elastic_barrier_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int REG_INDEX_WIDTH = DEFAULT_REG_INDEX_WIDTH,
  parameter int STALL_CNT_WIDTH = DEFAULT_STALL_CNT_WIDTH
);

  logic                       flush;
  logic                       exValid;
  logic                       exReady;
  logic [DATA_WIDTH-1:0]      exAluResult;
  logic [DATA_WIDTH-1:0]      exMemoryWriteData;
  logic [REG_INDEX_WIDTH-1:0] exWriteRegisterIndex;
  logic                       exMemWrite;
  logic                       exMemToReg;
  logic                       exRegWrite;
  logic                       memValid;
  logic                       memReady;
  logic [DATA_WIDTH-1:0]      memAluResult;
  logic [DATA_WIDTH-1:0]      memMemoryWriteData;
  logic [REG_INDEX_WIDTH-1:0] memWriteRegisterIndex;
  logic                       memMemWrite;
  logic                       memMemToReg;
  logic                       memRegWrite;
  logic [STALL_CNT_WIDTH-1:0] stallCycles;

  modport slave (
    input  flush, exValid, exAluResult, exMemoryWriteData, exWriteRegisterIndex,
           exMemWrite, exMemToReg, exRegWrite, memReady,
    output exReady, memValid, memAluResult, memMemoryWriteData, memWriteRegisterIndex,
           memMemWrite, memMemToReg, memRegWrite, stallCycles
  );

  modport master (
    output flush, exValid, exAluResult, exMemoryWriteData, exWriteRegisterIndex,
           exMemWrite, exMemToReg, exRegWrite, memReady,
    input  exReady, memValid, memAluResult, memMemoryWriteData, memWriteRegisterIndex,
           memMemWrite, memMemToReg, memRegWrite, stallCycles
  );

endinterface
`default_nettype wire

// File: rtl/ex_mem_elastic_barrier_pipe_payload_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pipe_payload_reg                                               |
// | Brief  : Loadable payload register with synchronous clear. Holds its    |
// |          value whenever load is low.                                   |
// | Rev    : 1.0 - initial release                                          |
// +------------------------------------------------------------------------+
module pipe_payload_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // Clear on reset, otherwise capture only when the owning entry is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_elastic_barrier.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : ex_mem_elastic_barrier                                         |
// | Brief  : EX->MEM pipeline register with valid/ready handshake, a        |
// |          2-entry (main + skid) buffer, flush, write gating of bubbles  |
// |          and a saturating back-pressure cycle counter.                 |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module ex_mem_elastic_barrier
  import ex_mem_elastic_barrier_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int REG_INDEX_WIDTH = DEFAULT_REG_INDEX_WIDTH,
  parameter int STALL_CNT_WIDTH = DEFAULT_STALL_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  ex_mem_elastic_barrier_if.slave  pipe
);

  localparam int PW        = payload_width(DATA_WIDTH, REG_INDEX_WIDTH);
  localparam int WDATA_LSB = pl_wdata_lsb(REG_INDEX_WIDTH);
  localparam int ALU_LSB   = pl_alu_lsb(DATA_WIDTH, REG_INDEX_WIDTH);

  logic                       mainValid_q, mainValid_d;
  logic                       skidValid_q, skidValid_d;
  logic                       mainLoad, skidLoad;
  logic                       inFire, outFire, mainFree;
  logic [PW-1:0]              incoming;
  logic [PW-1:0]              mainPayload_d;
  logic [PW-1:0]              mainPayload_q;
  logic [PW-1:0]              skidPayload_q;
  logic [STALL_CNT_WIDTH-1:0] stallCycles_q, stallCycles_d;

  assign incoming = {pipe.exAluResult, pipe.exMemoryWriteData, pipe.exWriteRegisterIndex,
                     pipe.exMemWrite, pipe.exMemToReg, pipe.exRegWrite};

  // Ready depends only on skid occupancy, so memReady never reaches exReady.
  assign pipe.exReady = ~skidValid_q & ~reset;
  assign inFire       = pipe.exValid & pipe.exReady;
  assign outFire      = mainValid_q & pipe.memReady;
  assign mainFree     = ~mainValid_q | outFire;

  // Occupancy update: flush wins, then refill main (skid first to keep order), else park in skid.
  always_comb begin
    mainValid_d   = mainValid_q;
    skidValid_d   = skidValid_q;
    mainLoad      = 1'b0;
    skidLoad      = 1'b0;
    mainPayload_d = skidValid_q ? skidPayload_q : incoming;
    if (pipe.flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (mainFree) begin
      if (skidValid_q) begin
        mainValid_d = 1'b1;
        mainLoad    = 1'b1;
        skidValid_d = inFire;
        skidLoad    = inFire;
      end else begin
        mainValid_d = inFire;
        mainLoad    = inFire;
      end
    end else if (inFire) begin
      skidValid_d = 1'b1;
      skidLoad    = 1'b1;
    end
  end

  // Valid bits of both entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
    end else begin
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
    end
  end

  pipe_payload_reg #(.WIDTH(PW)) u_main_payload (
    .clk   (clk),
    .reset (reset),
    .load  (mainLoad),
    .d     (mainPayload_d),
    .q     (mainPayload_q)
  );

  pipe_payload_reg #(.WIDTH(PW)) u_skid_payload (
    .clk   (clk),
    .reset (reset),
    .load  (skidLoad),
    .d     (incoming),
    .q     (skidPayload_q)
  );

  // Count cycles where a held beat is refused by MEM, sticking at all-ones.
  always_comb begin
    stallCycles_d = stallCycles_q;
    if (mainValid_q && !pipe.memReady && !(&stallCycles_q)) begin
      stallCycles_d = stallCycles_q + 1'b1;
    end
  end

  // Counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCycles_q <= '0;
    end else begin
      stallCycles_q <= stallCycles_d;
    end
  end

  assign pipe.memValid              = mainValid_q;
  assign pipe.memAluResult          = mainPayload_q[ALU_LSB +: DATA_WIDTH];
  assign pipe.memMemoryWriteData    = mainPayload_q[WDATA_LSB +: DATA_WIDTH];
  assign pipe.memWriteRegisterIndex = mainPayload_q[PL_IDX_LSB +: REG_INDEX_WIDTH];
  assign pipe.memMemToReg           = mainPayload_q[PL_MEM_TO_REG_BIT];
  // Bubbles must never write memory or the register file.
  assign pipe.memMemWrite           = mainPayload_q[PL_MEM_WRITE_BIT] & mainValid_q;
  assign pipe.memRegWrite           = mainPayload_q[PL_REG_WRITE_BIT] & mainValid_q;
  assign pipe.stallCycles           = stallCycles_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_elastic_barrier.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_ex_mem_elastic_barrier                                      |
// | Brief  : Table-driven bench with a queue reference model for the        |
// |          EX->MEM elastic barrier (4-bit stall counter instance).       |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module tb_ex_mem_elastic_barrier;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int SW = 4;
  localparam int SAT = (1 << SW) - 1;

  typedef struct {
    bit          rst;
    bit          fl;
    bit          v;
    logic [31:0] alu;
    bit          mw;
    bit          m2r;
    bit          rw;
    bit          mr;
  } vec_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  idx;
    bit          mw;
    bit          m2r;
    bit          rw;
  } beat_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cnt_model;
  beat_t sb[$];
  vec_t  tbl[$];

  ex_mem_elastic_barrier_if #(.DATA_WIDTH(DW), .REG_INDEX_WIDTH(RW), .STALL_CNT_WIDTH(SW)) bus ();

  ex_mem_elastic_barrier #(.DATA_WIDTH(DW), .REG_INDEX_WIDTH(RW), .STALL_CNT_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .pipe  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit rst, bit fl, bit v, logic [31:0] alu, bit mw, bit m2r, bit rw, bit mr);
    vec_t t;
    t.rst = rst; t.fl = fl; t.v = v; t.alu = alu;
    t.mw = mw; t.m2r = m2r; t.rw = rw; t.mr = mr;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the reference queue model, then compare after the edge.
  task automatic apply(input vec_t t);
    beat_t b;
    bit fire_in;
    bit fire_out;
    reset                    = t.rst;
    bus.flush                = t.fl;
    bus.exValid              = t.v;
    bus.exAluResult          = t.alu;
    bus.exMemoryWriteData    = ~t.alu;
    bus.exWriteRegisterIndex = t.alu[4:0];
    bus.exMemWrite           = t.mw;
    bus.exMemToReg           = t.m2r;
    bus.exRegWrite           = t.rw;
    bus.memReady             = t.mr;
    if (t.rst) begin
      sb.delete();
      cnt_model = 0;
    end else begin
      if (sb.size() > 0 && !t.mr && cnt_model < SAT) cnt_model++;
      if (t.fl) begin
        sb.delete();
      end else begin
        fire_in  = t.v && (sb.size() < 2);
        fire_out = (sb.size() > 0) && t.mr;
        if (fire_out) void'(sb.pop_front());
        if (fire_in) begin
          b.alu = t.alu; b.wd = ~t.alu; b.idx = t.alu[4:0];
          b.mw = t.mw; b.m2r = t.m2r; b.rw = t.rw;
          sb.push_back(b);
        end
      end
    end
    @(posedge clk);
    #1;
    check("exReady", {31'b0, bus.exReady}, {31'b0, (!t.rst && sb.size() < 2)});
    check("memValid", {31'b0, bus.memValid}, {31'b0, (sb.size() > 0)});
    if (sb.size() > 0) begin
      check("memAluResult", bus.memAluResult, sb[0].alu);
      check("memWdata", bus.memMemoryWriteData, sb[0].wd);
      check("memIdx", {27'b0, bus.memWriteRegisterIndex}, {27'b0, sb[0].idx});
      check("memMemToReg", {31'b0, bus.memMemToReg}, {31'b0, sb[0].m2r});
      check("memMemWrite", {31'b0, bus.memMemWrite}, {31'b0, sb[0].mw});
      check("memRegWrite", {31'b0, bus.memRegWrite}, {31'b0, sb[0].rw});
    end else begin
      check("memMemWrite_gated", {31'b0, bus.memMemWrite}, 32'd0);
      check("memRegWrite_gated", {31'b0, bus.memRegWrite}, 32'd0);
    end
    if (t.rst) check("reset_alu", bus.memAluResult, 32'd0);
    check("stallCycles", {28'b0, bus.stallCycles}, cnt_model);
  endtask

  initial begin
    total = 0;
    bad = 0;
    cnt_model = 0;
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.exValid = 1'b0;
    bus.exAluResult = '0;
    bus.exMemoryWriteData = '0;
    bus.exWriteRegisterIndex = '0;
    bus.exMemWrite = 1'b0;
    bus.exMemToReg = 1'b0;
    bus.exRegWrite = 1'b0;
    bus.memReady = 1'b0;

    // Reset held two cycles with a valid beat presented.
    tbl.push_back(mk(1, 0, 1, 32'hAA, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 32'hAA, 1, 1, 1, 1));
    // Streaming 1..4 with memReady high, then drain.
    tbl.push_back(mk(0, 0, 1, 32'd1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'd2, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'd3, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'd4, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 32'd0, 0, 0, 0, 1));
    // Back-pressure: A accepted, B skids, C held, then release in order.
    tbl.push_back(mk(1, 0, 0, 32'd0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h10, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h20, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h30, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h30, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h30, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h30, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 1));
    // Flush with both entries full and a beat on the input.
    tbl.push_back(mk(1, 0, 0, 32'd0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 32'h10, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h20, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h30, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 1));
    // Bubble gating: write enables asserted while exValid is low.
    tbl.push_back(mk(0, 0, 1, 32'h66, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h55, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h55, 1, 1, 1, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Saturation: one beat held against memReady=0 for 20 cycles.
    apply(mk(1, 0, 0, 32'd0, 0, 0, 0, 1));
    apply(mk(0, 0, 1, 32'h77, 1, 1, 1, 0));
    for (int i = 0; i < 20; i++) apply(mk(0, 0, 0, 32'd0, 0, 0, 0, 0));
    check("sat_value", {28'b0, bus.stallCycles}, SAT);
    apply(mk(0, 0, 0, 32'd0, 0, 0, 0, 0));
    check("sat_hold", {28'b0, bus.stallCycles}, SAT);
    apply(mk(0, 0, 0, 32'd0, 0, 0, 0, 1));
    apply(mk(0, 0, 0, 32'd0, 0, 0, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
